// File: rtl/sample_ram_controller_pkg.sv
// Shared definitions for the sample RAM controller and the trigger buffer controller:
// FSM encoding, frame-length width and RAM depth derivation.
package sample_ram_controller_pkg;

    // Frame length width, common with the buffer controller's num_samples output.
    localparam int NUM_SAMPLES_W = 16;

    localparam logic [1:0] ENC_WRITING = 2'd0;
    localparam logic [1:0] ENC_FETCH   = 2'd1;
    localparam logic [1:0] ENC_PRESENT = 2'd2;
    localparam logic [1:0] ENC_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_WRITING = ENC_WRITING,
        ST_FETCH   = ENC_FETCH,
        ST_PRESENT = ENC_PRESENT,
        ST_DONE    = ENC_DONE
    } state_t;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/sample_ram_controller_sample_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Same-address read and write in one cycle returns the old contents (read-first).
module sample_ram
    import sample_ram_controller_pkg::*;
#(
    parameter int BITS_ADC  = 8,
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [BITS_ADC-1:0]  wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [BITS_ADC-1:0]  rdata
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [BITS_ADC-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // read register, which drives a handshake output, is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: sequential state is always assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_ram_controller.sv
// Circular ADC sample store with oldest-first frame readout over a rdy/ack handshake.
// Define SAMPLE_RAM_FILL_TRACK_EN to clip readouts to the number of samples actually written.
module sample_ram_controller
    import sample_ram_controller_pkg::*;
#(
    parameter int BITS_ADC  = 8,
    parameter int ADDR_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS_ADC-1:0]      input_sample,
    input  logic                     input_rdy,
    input  logic                     write_enable,
    input  logic [NUM_SAMPLES_W-1:0] num_samples,
    input  logic                     send_data_rdy,
    output logic                     send_data_ack,
    output logic [BITS_ADC-1:0]      out_data,
    output logic                     out_rdy,
    input  logic                     out_ack
);

    localparam int DEPTH = depth_of(ADDR_BITS);
    localparam int CNT_W = ADDR_BITS + 1;
    localparam logic [NUM_SAMPLES_W:0] DEPTH_EXT = (NUM_SAMPLES_W + 1)'(DEPTH);

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     n_eff;
    logic                 capture;
    logic                 start;
    logic [NUM_SAMPLES_W:0] num_ext;

    assign num_ext = {1'b0, num_samples};
    assign capture = (state == ST_WRITING) && write_enable && input_rdy;
    assign start   = (state == ST_WRITING) && !write_enable && send_data_rdy;

`ifdef SAMPLE_RAM_FILL_TRACK_EN
    logic [CNT_W-1:0] fill;

    // Saturates at DEPTH: once the RAM has wrapped every location holds a real sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (capture && (fill != CNT_W'(DEPTH))) begin
            fill <= fill + CNT_W'(1);
        end
    end

    always_comb begin
        n_eff = (num_ext > DEPTH_EXT) ? CNT_W'(DEPTH) : CNT_W'(num_ext);
        if (n_eff > fill) begin
            n_eff = fill;
        end
    end
`else
    always_comb begin
        n_eff = (num_ext > DEPTH_EXT) ? CNT_W'(DEPTH) : CNT_W'(num_ext);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_WRITING;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        out_rdy       = 1'b0;
        send_data_ack = 1'b0;
        unique case (state)
            ST_WRITING: begin
                if (start) begin
                    state_next = (n_eff == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                out_rdy = 1'b1;
                if (out_ack) begin
                    state_next = (count == CNT_W'(1)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                send_data_ack = 1'b1;
                state_next    = ST_WRITING;
            end
            default: begin
                state_next = ST_WRITING;
            end
        endcase
    end

    // Pointers wrap naturally at DEPTH; rd_ptr starts n_eff words behind the write head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (start) begin
                rd_ptr <= wr_ptr - n_eff[ADDR_BITS-1:0];
                count  <= n_eff;
            end else if ((state == ST_PRESENT) && out_ack) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    sample_ram #(
        .BITS_ADC  (BITS_ADC),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (input_sample),
        .re    (state == ST_FETCH),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: doc/sample_ram_controller.md
# sample_ram_controller

Circular sample store between the ADC controller and the PC communication controller, directly downstream of the trigger buffer controller. Writes every ready ADC sample into a power-of-two RAM while `write_enable` is high. When the buffer controller raises `send_data_rdy`, it reads the last `num_samples` samples back, oldest first, over a rdy/ack word handshake. After the last word it pulses `send_data_ack` back to the buffer controller.

## Interface
- `BITS_ADC`, 8: sample width.
- `ADDR_BITS`, 12: RAM address width; DEPTH = 2^ADDR_BITS.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `input_sample`  input  BITS_ADC  sample from ADC controller.
- `input_rdy`  input  1  sample valid for one cycle.
- `write_enable`  input  1  from buffer controller; high = capture samples.
- `num_samples`  input  16  frame length; sampled when a read is started.
- `send_data_rdy`  input  1  level from buffer controller; frame complete, start readout.
- `send_data_ack`  output  1  one-cycle pulse when readout is finished.
- `out_data`  output  BITS_ADC  word to PC communication controller.
- `out_rdy`  output  1  `out_data` valid.
- `out_ack`  input  1  consumer accepted `out_data`.

## Operation
- **States:** ST_WRITING, ST_FETCH, ST_PRESENT, ST_DONE.
- **Reset values:** state = ST_WRITING, wr_ptr = 0, rd_ptr = 0, count = 0, `out_rdy` = 0, `out_data` = 0, `send_data_ack` = 0. RAM contents are not reset.
- **ST_WRITING, capture:**
  - If `write_enable` && `input_rdy`: mem[wr_ptr] <= `input_sample`, and wr_ptr increments modulo DEPTH (natural wrap).
  - Writes are accepted only in this state. Samples arriving in any other state are dropped.
- **ST_WRITING, start of readout:**
  - If `write_enable` == 0 && `send_data_rdy` == 1, compute n_eff = min(`num_samples`, DEPTH) (17-bit compare).
  - If n_eff == 0: go to ST_DONE.
  - Otherwise: rd_ptr <= wr_ptr − n_eff (mod DEPTH), count <= n_eff, go to ST_FETCH.
  - If a capture and a readout start occur in the same cycle, the capture is ignored (`write_enable` is low by definition).
- **ST_FETCH:** RAM read address = rd_ptr. Data is registered into `out_data` at the end of the cycle. `out_rdy` <= 1; go to ST_PRESENT.
- **ST_PRESENT:**
  - `out_data` and `out_rdy` hold until `out_ack` is sampled high.
  - On ack: `out_rdy` <= 0, rd_ptr++ (wrapping), count--.
  - If count was 1, go to ST_DONE; otherwise go to ST_FETCH.
  - `out_ack` while `out_rdy` is 0 is ignored.
- **ST_DONE:** `send_data_ack` = 1 for exactly this cycle, then return to ST_WRITING. wr_ptr is untouched, so capture resumes at the same address.
- **`send_data_rdy` behaviour:** it drops at the same edge that sees the ack, so it cannot retrigger a readout.
- **Reset mid-readout:** readout is aborted, outputs go to their reset values, wr_ptr returns to 0.

## Timing
- `send_data_rdy` sampled high → first `out_rdy` = 2 cycles later (start edge, FETCH edge).
- Minimum 2 cycles per word: FETCH, then PRESENT with same-cycle `out_ack`.
- `out_ack` sampled in the last PRESENT → `send_data_ack` high in the next cycle (ST_DONE).
- A sample written at edge k is readable from the FETCH at edge k+1 or later. The RAM is read-first.

## Configuration
- **`SAMPLE_RAM_FILL_TRACK_EN` defined:**
  - A fill counter (saturating at DEPTH) counts writes since reset.
  - n_eff = min(`num_samples`, DEPTH, fill), and rd_ptr = wr_ptr − n_eff.
  - Unwritten locations are never read. If fill == 0, go straight to ST_DONE.
- **Not defined:** no fill counter. n_eff = min(`num_samples`, DEPTH). Unwritten locations return undefined RAM contents.

## Structure
- **Shared package:** state encoding localparams, the DEPTH derivation, and the 16-bit `num_samples` width, common with the buffer controller.
- **Sub-module `sample_ram`:** simple dual-port synchronous RAM (one write port, one registered read port, parameters BITS_ADC and ADDR_BITS). The controller holds the FSM, pointers and handshake only.

## Test plan
Use ADDR_BITS = 4 (DEPTH = 16) for all scenarios.
- **Basic readout:** write samples 1..10, drop `write_enable`, `num_samples` = 4, raise `send_data_rdy` → outputs 7, 8, 9, 10, then one `send_data_ack` pulse.
- **Wrap-around:** write 0..39, `num_samples` = 16 → outputs 24..39. Then `num_samples` = 20 → clipped to 16 words.
- **Backpressure:** hold `out_ack` low for 5 cycles on word 2 → `out_data` is stable and `out_rdy` stays high. Samples offered with `input_rdy` during readout are not written.
- **`num_samples` = 0:** `send_data_ack` asserts 1 cycle after the start edge, with no `out_rdy`.
- **Reset mid-readout:** assert `rst` low in ST_PRESENT → `out_rdy` = 0 immediately, the next capture writes address 0.
- **`SAMPLE_RAM_FILL_TRACK_EN`:** write 3 samples (5, 6, 7) after reset, `num_samples` = 8 → outputs exactly 5, 6, 7, then ack.
